// File: rtl/freqmeter_channel.sv
`default_nettype none
// ============================================================================
// Module   : freqmeter_channel
// Brief    : Reciprocal frequency meter for one asynchronous input. Counts
//            reference cycles across N input rising edges and hands each
//            result to the readout side through a valid/ack pair.
// Revision : 1.0
// ============================================================================
module freqmeter_channel #(
    parameter int PERIOD_W    = 24,
    parameter int TIMER_W     = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                f_in,
    input  logic                enable_i,
    input  logic [PERIOD_W-1:0] periods_i,
    output logic [TIMER_W-1:0]  ref_count_o,
    output logic [PERIOD_W-1:0] periods_o,
    output logic                valid_o,
    input  logic                ack_i,
    output logic                overrun_o,
    output logic                timeout_o,
    output logic                busy_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARM   = 2'd1;
    localparam logic [1:0] S_COUNT = 2'd2;

    logic [1:0]             r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic [TIMER_W-1:0]     r_cnt;
    logic [PERIOD_W-1:0]    r_rem;
    logic [PERIOD_W-1:0]    r_tgt;
    logic [TIMER_W-1:0]     r_ref_count;
    logic [PERIOD_W-1:0]    r_periods;
    logic                   r_valid;
    logic                   r_overrun;
    logic                   r_timeout;

    logic                   w_edge;
    logic                   w_cnt_sat;
    logic [PERIOD_W-1:0]    w_periods_eff;

    assign w_edge        = r_sync[SYNC_STAGES-1] & ~r_s_d;
    assign w_cnt_sat     = &r_cnt;
    assign w_periods_eff = (periods_i == '0) ? PERIOD_W'(1) : periods_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_sync      <= '0;
            r_s_d       <= 1'b0;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_tgt       <= '0;
            r_ref_count <= '0;
            r_periods   <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], f_in};
            r_s_d  <= r_sync[SYNC_STAGES-1];

            // A result published later in this block overrides the ack clear.
            if (ack_i && r_valid) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end

            if (!enable_i) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_ARM;
                    end
                    S_ARM: begin
                        if (w_edge) begin
                            r_tgt   <= w_periods_eff;
                            r_rem   <= w_periods_eff;
                            r_cnt   <= TIMER_W'(1);
                            r_state <= S_COUNT;
                        end
                    end
                    S_COUNT: begin
                        if (w_edge && (r_rem == PERIOD_W'(1))) begin
                            // Closing edge doubles as the opening edge of the next window.
                            r_ref_count <= r_cnt;
                            r_periods   <= r_tgt;
                            r_timeout   <= 1'b0;
                            r_valid     <= 1'b1;
                            r_overrun   <= r_valid & ~ack_i;
                            r_cnt       <= TIMER_W'(1);
                            r_tgt       <= w_periods_eff;
                            r_rem       <= w_periods_eff;
                        end else if (w_cnt_sat) begin
                            r_ref_count <= '1;
                            r_periods   <= r_tgt;
                            r_timeout   <= 1'b1;
                            r_valid     <= 1'b1;
                            r_overrun   <= r_valid & ~ack_i;
                            r_state     <= S_ARM;
                        end else begin
                            r_cnt <= r_cnt + TIMER_W'(1);
                            if (w_edge) begin
                                r_rem <= r_rem - PERIOD_W'(1);
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign ref_count_o = r_ref_count;
    assign periods_o   = r_periods;
    assign valid_o     = r_valid;
    assign overrun_o   = r_overrun;
    assign timeout_o   = r_timeout;
    assign busy_o      = (r_state == S_COUNT);

endmodule
`default_nettype wire
